// File: rtl/fifo_word_packer_if.sv
// Bundle of the FIFO read side, the flush request and the wide output stream
// used by fifo_word_packer. The master modport is the packer's view; the slave
// modport is the view of whatever sits around it (FIFO, consumer, bench).
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
);
  localparam int CNT_W = $clog2(PACK_RATIO + 1);

  logic                             fifo_empty;
  logic [DATA_WIDTH-1:0]            fifo_dout;
  logic                             fifo_rd_en;
  logic                             flush;
  logic                             m_valid;
  logic                             m_ready;
  logic [DATA_WIDTH*PACK_RATIO-1:0] m_data;
  logic [PACK_RATIO-1:0]            m_keep;
  logic [CNT_W-1:0]                 fill_cnt;

  modport master (
    input  fifo_empty, fifo_dout, flush, m_ready,
    output fifo_rd_en, m_valid, m_data, m_keep, fill_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_keep, fill_cnt
  );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a show-ahead FIFO word by word and packs PACK_RATIO
// consecutive words into one wide valid/ready beat (word 0 in the LSB lane).
// A flush pulse emits a partial beat; m_keep marks the filled lanes.
// Optional feature macro: PACKER_TIMEOUT_EN -- when defined, a partial beat
// that sits idle for TIMEOUT_CYCLES cycles is flushed automatically.
module fifo_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo_word_packer_if.master bus
);
  localparam int CNT_W = $clog2(PACK_RATIO + 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e                               state_r;
  state_e                               state_nxt_s;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lane_r;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lane_base_s;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lane_nxt_s;
  logic [PACK_RATIO-1:0]                keep_r;
  logic [PACK_RATIO-1:0]                keep_base_s;
  logic [PACK_RATIO-1:0]                keep_nxt_s;
  logic [CNT_W-1:0]                     cnt_r;
  logic [CNT_W-1:0]                     cnt_base_s;
  logic [CNT_W-1:0]                     cnt_nxt_s;
  logic                                 m_valid_r;
  logic                                 pop_s;
  logic                                 hs_s;
  logic                                 full_s;
  logic                                 flush_eff_s;

  // A beat leaves when held and accepted; the FIFO is popped whenever a word
  // is available and the lane buffer can take it (filling, or being freed
  // by this cycle's handshake). Reset blocks any pop.
  assign hs_s  = m_valid_r && bus.m_ready;
  assign pop_s = rst && !bus.fifo_empty && ((state_r == FILL) || hs_s);

`ifdef PACKER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_r;
  logic              timeout_s;

  assign timeout_s   = (state_r == FILL) && (idle_r == IDLE_W'(TIMEOUT_CYCLES));
  assign flush_eff_s = bus.flush || timeout_s;

  // Idle counter: counts stalled cycles of a non-empty partial beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_r <= '0;
    end else if (pop_s || bus.flush || hs_s || timeout_s) begin
      idle_r <= '0;
    end else if ((state_r == FILL) && (cnt_r != '0)) begin
      idle_r <= idle_r + IDLE_W'(1);
    end else begin
      idle_r <= '0;
    end
  end
`else
  assign flush_eff_s = bus.flush;
`endif

  // Next lane buffer: start from cleared lanes on a handshake, then drop a
  // popped word into the next free lane.
  always_comb begin
    lane_base_s = hs_s ? '0 : lane_r;
    keep_base_s = hs_s ? '0 : keep_r;
    cnt_base_s  = hs_s ? '0 : cnt_r;
    lane_nxt_s  = lane_base_s;
    keep_nxt_s  = keep_base_s;
    cnt_nxt_s   = cnt_base_s;
    if (pop_s) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        lane_nxt_s[i] = (cnt_base_s == CNT_W'(i)) ? bus.fifo_dout : lane_base_s[i];
        keep_nxt_s[i] = (cnt_base_s == CNT_W'(i)) ? 1'b1 : keep_base_s[i];
      end
      cnt_nxt_s = cnt_base_s + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_base_s;
    end
  end

  // A pop into the last lane completes the beat.
  assign full_s = pop_s && (cnt_base_s == CNT_W'(PACK_RATIO - 1));

  // Next state: complete or flushed partial beats move to EMIT; a handshake
  // always returns to FILL since one word can never complete a beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (full_s || (flush_eff_s && (cnt_nxt_s != '0))) begin
          state_nxt_s = EMIT;
        end else begin
          state_nxt_s = FILL;
        end
      end
      EMIT: begin
        if (hs_s) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: begin
        state_nxt_s = FILL;
      end
    endcase
  end

  // State, lane buffer and registered stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= FILL;
      lane_r    <= '0;
      keep_r    <= '0;
      cnt_r     <= '0;
      m_valid_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      lane_r    <= lane_nxt_s;
      keep_r    <= keep_nxt_s;
      cnt_r     <= cnt_nxt_s;
      m_valid_r <= (state_nxt_s == EMIT);
    end
  end

  assign bus.fifo_rd_en = pop_s;
  assign bus.m_valid    = m_valid_r;
  assign bus.m_data     = lane_r;
  assign bus.m_keep     = keep_r;
  assign bus.fill_cnt   = cnt_r;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: a queue-based FIFO feeds the DUT and a
// transaction-level model (word list + held beat) predicts every output.
module tb_fifo_word_packer;
  localparam int DW  = 8;
  localparam int PR  = 4;
  localparam int TMO = 16;
`ifdef PACKER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_word_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();

  fifo_word_packer #(
    .DATA_WIDTH(DW),
    .PACK_RATIO(PR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  fq[$];        // FIFO contents, head at index 0
  logic [7:0]  acc[$];       // model: words gathered toward the next beat
  bit          held;         // model: a beat is presented
  logic [31:0] held_data;
  logic [3:0]  held_keep;
  int          idle;         // model: idle cycles of a partial beat
  logic        exp_pop;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_dout  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic model_reset();
    held = 1'b0;
    held_data = 32'h0;
    held_keep = 4'h0;
    acc.delete();
    idle = 0;
  endtask

  // One clock cycle: drive inputs at negedge, compare, then advance the model
  // at the rising edge with the same inputs.
  task automatic step(input bit rdy, input bit fl);
    bit was_held;
    bit fire;
    int n_before;
    logic [31:0] d;
    @(negedge clk);
    bus.m_ready = rdy;
    bus.flush   = fl;
    drive_fifo();
    #1;
    exp_pop = rst && (fq.size() != 0) && (!held || rdy);
    check_eq("rd_en", bus.fifo_rd_en, exp_pop);
    check_eq("m_valid", bus.m_valid, held);
    if (held) begin
      check_eq("m_data", bus.m_data, held_data);
      check_eq("m_keep", bus.m_keep, held_keep);
    end
    check_eq("fill_cnt", bus.fill_cnt, held ? $countones(held_keep) : acc.size());
    @(posedge clk);
    was_held = held;
    n_before = acc.size();
    fire = TMO_EN && !was_held && (idle == TMO);
    if (held && rdy) held = 1'b0;
    if (exp_pop) acc.push_back(fq.pop_front());
    if (acc.size() == PR || (!was_held && (fl || fire) && acc.size() > 0)) begin
      d = 32'h0;
      foreach (acc[i]) d |= 32'(acc[i]) << (8 * i);
      held_data = d;
      held_keep = 4'((1 << acc.size()) - 1);
      held = 1'b1;
      acc.delete();
    end
    if (exp_pop || fl || (was_held && rdy) || fire) idle = 0;
    else if (!was_held && n_before > 0) idle++;
    else idle = 0;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k);
    #2;
    check_eq({tag, "_valid"}, bus.m_valid, 1'b1);
    check_eq({tag, "_data"}, bus.m_data, d);
    check_eq({tag, "_keep"}, bus.m_keep, k);
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
  endtask

  initial begin
    bus.m_ready = 1'b0;
    bus.flush   = 1'b0;
    model_reset();
    push(8'h5A);
    drive_fifo();
    #3 rst = 1'b0;
    #10;
    check_eq("rst_m_valid", bus.m_valid, 1'b0);
    check_eq("rst_m_data", bus.m_data, 32'h0);
    check_eq("rst_m_keep", bus.m_keep, 4'h0);
    check_eq("rst_fill_cnt", bus.fill_cnt, 3'd0);
    check_eq("rst_rd_en", bus.fifo_rd_en, 1'b0);
    fq.delete();
    @(negedge clk);
    drive_fifo();
    #1 rst = 1'b1;

    // Four words, always ready: single full beat
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (4) step(1'b1, 1'b0);
    expect_beat("t1", 32'h44332211, 4'b1111);
    step(1'b1, 1'b0);
    #2 check_eq("t1_one_cycle", bus.m_valid, 1'b0);

    // Eight words back to back: second beat overlaps first handshake
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (4) step(1'b1, 1'b0);
    expect_beat("t2a", 32'h04030201, 4'b1111);
    repeat (4) step(1'b1, 1'b0);
    expect_beat("t2b", 32'h08070605, 4'b1111);
    step(1'b1, 1'b0);

    // Back-pressure with a non-empty FIFO
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'h55);
    repeat (4) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      expect_beat("t3_hold", 32'hA4A3A2A1, 4'b1111);
    end
    step(1'b1, 1'b0);
    #2;
    check_eq("t3_lane0_cnt", bus.fill_cnt, 3'd1);
    check_eq("t3_lane0_data", bus.m_data, 32'h00000055);
    step(1'b0, 1'b1);
    expect_beat("t3_flush", 32'h00000055, 4'b0001);
    step(1'b1, 1'b0);

    // Flush of a two-word partial beat, then a flush with nothing held
    push(8'hAA); push(8'hBB);
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    expect_beat("t4", 32'h0000BBAA, 4'b0011);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    #2 check_eq("t4_empty_flush", bus.m_valid, 1'b0);

    // Flush coinciding with the third pop
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    expect_beat("t5", 32'h00CCBBAA, 4'b0111);
    step(1'b1, 1'b0);

    // Asynchronous reset while a beat is held
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    repeat (4) step(1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_m_valid", bus.m_valid, 1'b0);
    check_eq("t6_fill_cnt", bus.fill_cnt, 3'd0);
    check_eq("t6_m_keep", bus.m_keep, 4'h0);
    check_eq("t6_rd_en", bus.fifo_rd_en, 1'b0);
    model_reset();
    fq.delete();
    drive_fifo();
    @(negedge clk);
    #1 rst = 1'b1;

`ifdef PACKER_TIMEOUT_EN
    // One word then idle: beat appears without any flush pulse
    push(8'h77);
    step(1'b0, 1'b0);
    for (int i = 0; i < 40 && !bus.m_valid; i++) step(1'b0, 1'b0);
    expect_beat("tmo", 32'h00000077, 4'b0001);
    step(1'b1, 1'b0);
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (fq.size() < 8 && $urandom_range(0, 9) < 6) push(8'($urandom));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end
    for (int c = 0; c < 200 && (fq.size() != 0 || acc.size() != 0 || held); c++) begin
      step(1'b1, (c % 4) == 3);
    end
    #2 check_eq("drain_m_valid", bus.m_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
